// File: rtl/mips16_boot_loader_pkg.sv
// Shared types and defaults for the mips16 boot loader: FSM state encoding and word geometry.
package mips16_boot_loader_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 256;

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/mips16_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port between an image source and the loader.
interface mips16_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    import mips16_boot_loader_pkg::*;

    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               instr_wr_en;
    logic [ADDR_W-1:0]  instr_wr_addr;
    logic [INSTR_W-1:0] instr_wr_data;

    // Image source / observer side.
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  instr_wr_en,
        input  instr_wr_addr,
        input  instr_wr_data
    );

    // Loader side.
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output instr_wr_en,
        output instr_wr_addr,
        output instr_wr_data
    );

endinterface

// File: rtl/mips16_boot_loader.sv
// Streams a counted, XOR-checksummed image into instruction memory and holds the CPU in reset
// until the whole image has been written and its checksum matches.
module mips16_boot_loader
    import mips16_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    mips16_boot_loader_if.slave  bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_e              state_q;
    logic [INSTR_W-9:0]  word_q;      // three most recent bytes of the word in flight
    logic [1:0]          byte_cnt_q;
    logic [ADDR_W:0]     word_idx_q;  // one spare bit so N==DEPTH compares without wrapping
    logic [7:0]          acc_q;
    logic [7:0]          cnt_hi_q;
    logic [15:0]         count_q;

    logic                xfer;
    logic [15:0]         n_rx;
    logic [ADDR_W:0]     idx_next;

    assign xfer     = bus.byte_valid & bus.byte_ready;
    assign n_rx     = {cnt_hi_q, bus.byte_in};
    assign idx_next = word_idx_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StCntHi;
            word_q            <= '0;
            byte_cnt_q        <= '0;
            word_idx_q        <= '0;
            acc_q             <= '0;
            cnt_hi_q          <= '0;
            count_q           <= '0;
            bus.byte_ready    <= 1'b1;
            bus.instr_wr_en   <= 1'b0;
            bus.instr_wr_addr <= '0;
            bus.instr_wr_data <= '0;
            cpu_hold          <= 1'b1;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            bus.instr_wr_en <= 1'b0;
            unique case (state_q)
                StCntHi: begin
                    if (xfer) begin
                        cnt_hi_q <= bus.byte_in;
                        state_q  <= StCntLo;
                    end
                end
                StCntLo: begin
                    if (xfer) begin
                        count_q <= n_rx;
                        if (n_rx > DEPTH16) begin
                            state_q        <= StError;
                            error          <= 1'b1;
                            bus.byte_ready <= 1'b0;
                        end else if (n_rx == 16'd0) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        word_q     <= {word_q[INSTR_W-17:0], bus.byte_in};
                        acc_q      <= acc_q ^ bus.byte_in;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q           <= StWrite;
                            bus.byte_ready    <= 1'b0;
                            bus.instr_wr_en   <= 1'b1;
                            bus.instr_wr_addr <= word_idx_q[ADDR_W-1:0];
                            bus.instr_wr_data <= {word_q, bus.byte_in};
                        end
                    end
                end
                StWrite: begin
                    word_idx_q     <= idx_next;
                    bus.byte_ready <= 1'b1;
                    state_q        <= (16'(idx_next) == count_q) ? StCheck : StData;
                end
                StCheck: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_in == acc_q) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= StError;
                            error   <= 1'b1;
                        end
                    end
                end
                StDone, StError: ;
                default: begin
                    // Unreachable encoding: park safely with the CPU held.
                    state_q        <= StError;
                    error          <= 1'b1;
                    cpu_hold       <= 1'b1;
                    bus.byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips16_boot_loader.sv
// Self-checking bench for mips16_boot_loader: directed frames plus randomized frames and gaps,
// compared against a frame-level model of the loader.
module tb_mips16_boot_loader;
    import mips16_boot_loader_pkg::*;

    localparam int TB_DEPTH = 256;

    logic clock = 1'b0;
    logic reset;
    logic cpu_hold;
    logic done;
    logic error;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    logic prev_wr = 1'b0;

    logic [7:0] frame_q[$];

    mips16_boot_loader_if #(.ADDR_W(8)) lif ();

    mips16_boot_loader #(
        .ADDR_W (8),
        .DEPTH  (TB_DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (lif),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Strobe counting, single-cycle strobe width and done/error exclusivity.
    always @(negedge clock) begin
        if (lif.instr_wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (prev_wr === 1'b1) begin
                errors++;
                $display("FAIL strobe_width: instr_wr_en high two cycles running, required 1 cycle");
            end
        end
        prev_wr = lif.instr_wr_en;
        if (done === 1'b1 || error === 1'b1) begin
            checks++;
            if (done === 1'b1 && error === 1'b1) begin
                errors++;
                $display("FAIL done_error_excl: done=%b error=%b, required not both 1", done, error);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset          = 1'b1;
        lif.byte_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        lif.byte_valid = 1'b0;
        lif.byte_in    = 8'($urandom);
        repeat (gap) @(negedge clock);
        lif.byte_valid = 1'b1;
        lif.byte_in    = b;
        waited         = 0;
        while (lif.byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (lif.byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept: byte_ready=%b after %0d cycles, required 1", lif.byte_ready,
                     waited);
            lif.byte_valid = 1'b0;
            return;
        end
        @(negedge clock);
        lif.byte_valid = 1'b0;
        lif.byte_in    = 8'($urandom);
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [15:0] nn;
        logic [7:0]  b;
        logic [7:0]  x;
        nn = 16'(n);
        x  = 8'h00;
        frame_q.delete();
        frame_q.push_back(nn[15:8]);
        frame_q.push_back(nn[7:0]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    // Sends frame_q and checks every write and the final status against the frame model.
    task automatic run_frame(input int max_gap, input string name);
        int          n;
        int          wr_before;
        int          exp_writes;
        bit          oversize;
        bit          exp_done;
        logic [7:0]  x;
        logic [31:0] exp_word;
        n        = int'({frame_q[0], frame_q[1]});
        oversize = (n > TB_DEPTH);
        exp_done = 1'b0;
        if (!oversize) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) x = x ^ frame_q[2 + i];
            exp_done = (frame_q[2 + 4 * n] == x);
        end
        exp_writes = oversize ? 0 : n;
        wr_before  = wr_count;
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
            if (!oversize && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
                exp_word = {frame_q[i - 3], frame_q[i - 2], frame_q[i - 1], frame_q[i]};
                checks++;
                if (lif.instr_wr_en !== 1'b1 || lif.instr_wr_addr !== 8'((i - 2) / 4) ||
                    lif.instr_wr_data !== exp_word) begin
                    errors++;
                    $display("FAIL %s_write: en=%b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                             name, lif.instr_wr_en, lif.instr_wr_addr, lif.instr_wr_data,
                             (i - 2) / 4, exp_word);
                end
            end
        end
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL %s_done: done=%b, required %b", name, done, exp_done);
        end
        checks++;
        if (error !== !exp_done) begin
            errors++;
            $display("FAIL %s_error: error=%b, required %b", name, error, !exp_done);
        end
        checks++;
        if (cpu_hold !== !exp_done) begin
            errors++;
            $display("FAIL %s_cpu_hold: cpu_hold=%b, required %b", name, cpu_hold, !exp_done);
        end
        checks++;
        if (lif.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_end: byte_ready=%b, required 0", name, lif.byte_ready);
        end
        checks++;
        if (wr_count - wr_before !== exp_writes) begin
            errors++;
            $display("FAIL %s_write_count: writes=%0d, required %0d", name, wr_count - wr_before,
                     exp_writes);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (lif.byte_ready !== 1'b1 || lif.instr_wr_en !== 1'b0 || lif.instr_wr_addr !== 8'd0 ||
            lif.instr_wr_data !== 32'd0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b en=%b addr=%0d data=%h hold=%b done=%b err=%b, %s",
                     lif.byte_ready, lif.instr_wr_en, lif.instr_wr_addr, lif.instr_wr_data,
                     cpu_hold, done, error, "required 1 0 0 0 1 0 0");
        end
    endtask

    task automatic load_frame1(input logic [7:0] csum);
        frame_q = {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, csum};
    endtask

    task automatic test_load_n2();
        apply_reset();
        load_frame1(8'h24);
        run_frame(0, "load_n2");
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        load_frame1(8'h25);
        run_frame(0, "bad_csum");
    endtask

    task automatic test_oversize();
        apply_reset();
        frame_q = {8'h01, 8'h01};
        run_frame(0, "oversize");
        apply_reset();
        frame_q = {8'hff, 8'h00};
        run_frame(2, "oversize_big");
    endtask

    task automatic test_full_depth();
        apply_reset();
        build_frame(TB_DEPTH, 1'b0);
        run_frame(0, "full_depth");
    endtask

    task automatic test_zero_count();
        apply_reset();
        frame_q = {8'h00, 8'h00, 8'h00};
        run_frame(0, "zero_ok");
        apply_reset();
        frame_q = {8'h00, 8'h00, 8'h01};
        run_frame(0, "zero_bad");
    endtask

    task automatic test_gaps();
        apply_reset();
        load_frame1(8'h24);
        run_frame(5, "gaps");
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        load_frame1(8'h24);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
        apply_reset();
        checks++;
        if (cpu_hold !== 1'b1 || lif.byte_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: hold=%b ready=%b err=%b done=%b, required 1 1 0 0",
                     cpu_hold, lif.byte_ready, error, done);
        end
        run_frame(0, "after_mid_reset");
    endtask

    task automatic test_reset_in_done();
        apply_reset();
        load_frame1(8'h24);
        run_frame(0, "pre_done_reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_reset_hold: cpu_hold=%b done=%b, required 1 0", cpu_hold, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            apply_reset();
            build_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0));
            run_frame(int'($urandom_range(0, 5)), "random");
        end
    endtask

    initial begin
        reset          = 1'b1;
        lif.byte_valid = 1'b0;
        lif.byte_in    = 8'h00;
        test_reset();
        test_load_n2();
        test_bad_checksum();
        test_oversize();
        test_zero_count();
        test_gaps();
        test_reset_mid_load();
        test_reset_in_done();
        test_full_depth();
        test_random();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
